stopwatch_core: RTL

- Parametrised stopwatch controller: debounced start/pause and clear buttons, run/pause/adjust state machine, BCD mm:ss counter, multiplexed 4-digit 7-segment drive.
- All timing is derived from one clock using clock-enable ticks; there are no derived clocks.
- Instantiated directly under the board top, fed by the board clock, buttons and switches.

---
 rtl/stopwatch_core.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch controller: debounced pause/clear buttons, PAUSE/RUN/ADJUST FSM, BCD mm:ss, 4-digit mux.
// Define STOPWATCH_LAP_EN to add btn_lap and the lap-hold display.

module stopwatch_debounce #(
   parameter int DEB_CYC = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEB_CYC + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          level, level_q;

   // level only moves after DEB_CYC consecutive samples disagreeing with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync    <= 2'b00;
         cnt     <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync    <= {sync[0], raw};
         level_q <= level;
         if (sync[1] == level)
            cnt <= '0;
         else if (cnt == CW'(DEB_CYC - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else
            cnt <= cnt + CW'(1);
      end
   end

   assign press = level & ~level_q;
endmodule

module stopwatch_core #(
   parameter int CLK_HZ  = 100000000,
   parameter int ADJ_HZ  = 2,
   parameter int SCAN_HZ = 1000,
   parameter int DEB_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_pause,
   input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
   input  logic       btn_lap,
`endif
   input  logic       sw_adj,
   input  logic       sw_sel,
   output logic [2:0] min1,
   output logic [3:0] min0,
   output logic [2:0] sec1,
   output logic [3:0] sec0,
   output logic       running,
   output logic [3:0] an,
   output logic [7:0] seg
);
   localparam int ADJ_DIV  = CLK_HZ / ADJ_HZ;
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int W1S  = $clog2(CLK_HZ + 1);
   localparam int WADJ = $clog2(ADJ_DIV + 1);
   localparam int WSCN = $clog2(SCAN_DIV + 1);

   typedef enum logic [1:0] {PAUSE, RUN, ADJUST} state_t;

`ifdef STOPWATCH_LAP_EN
   localparam int NUM_BTN = 3;
`else
   localparam int NUM_BTN = 2;
`endif

   logic [NUM_BTN-1:0] btn_raw, press;
   logic               p_press, c_press;

`ifdef STOPWATCH_LAP_EN
   assign btn_raw = {btn_lap, btn_clear, btn_pause};
`else
   assign btn_raw = {btn_clear, btn_pause};
`endif
   assign p_press = press[0];
   assign c_press = press[1];

   genvar gi;
   for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      stopwatch_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[gi]),
         .press (press[gi])
      );
   end

   logic [1:0] adj_sync, sel_sync;
   logic       adj_s, sel_s;
   assign adj_s = adj_sync[1];
   assign sel_s = sel_sync[1];

   state_t state, state_nxt;
   logic [W1S-1:0]  cnt_1s;
   logic [WADJ-1:0] cnt_adj;
   logic [WSCN-1:0] cnt_scan;
   logic            tick_1s, tick_adj, tick_scan;
   logic [6:0]      sec_t, min_t;     // {tens[2:0], units[3:0]}
   logic [7:0]      sec_inc, min_inc; // {wrap, tens, units}
   logic            blink;
   logic [1:0]      scan_idx;

   assign tick_1s   = (state == RUN) && (cnt_1s == W1S'(CLK_HZ - 1));
   assign tick_adj  = (cnt_adj == WADJ'(ADJ_DIV - 1));
   assign tick_scan = (cnt_scan == WSCN'(SCAN_DIV - 1));

   function automatic logic [7:0] inc60(input logic [6:0] f);
      if (f[3:0] != 4'd9)      return {1'b0, f[6:4], f[3:0] + 4'd1};
      else if (f[6:4] != 3'd5) return {1'b0, f[6:4] + 3'd1, 4'd0};
      else                     return 8'h80;
   endfunction

   function automatic logic [6:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   assign sec_inc = inc60(sec_t);
   assign min_inc = inc60(min_t);

   always_comb begin
      state_nxt = state;
      if (adj_s)
         state_nxt = ADJUST;
      else begin
         case (state)
            PAUSE:   if (p_press) state_nxt = RUN;
            RUN:     if (p_press) state_nxt = PAUSE;
            default: state_nxt = PAUSE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= PAUSE;
         adj_sync <= 2'b00;
         sel_sync <= 2'b00;
         cnt_1s   <= '0;
         cnt_adj  <= '0;
         cnt_scan <= '0;
         blink    <= 1'b0;
         scan_idx <= 2'd0;
      end else begin
         state    <= state_nxt;
         adj_sync <= {adj_sync[0], sw_adj};
         sel_sync <= {sel_sync[0], sw_sel};
         cnt_adj  <= tick_adj  ? '0 : cnt_adj + WADJ'(1);
         cnt_scan <= tick_scan ? '0 : cnt_scan + WSCN'(1);
         if (c_press || state != RUN || tick_1s) cnt_1s <= '0;
         else                                    cnt_1s <= cnt_1s + W1S'(1);
         if (tick_adj)  blink    <= ~blink;
         if (tick_scan) scan_idx <= scan_idx + 2'd1;
      end
   end

   // clear beats both count sources; adjust never carries between fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_t <= 7'd0;
         min_t <= 7'd0;
      end else if (c_press) begin
         sec_t <= 7'd0;
         min_t <= 7'd0;
      end else if (tick_1s) begin
         sec_t <= sec_inc[6:0];
         if (sec_inc[7]) min_t <= min_inc[6:0];
      end else if (state == ADJUST && tick_adj) begin
         if (sel_s) sec_t <= sec_inc[6:0];
         else       min_t <= min_inc[6:0];
      end
   end

   logic [6:0] disp_sec, disp_min;

`ifdef STOPWATCH_LAP_EN
   logic       lap_hold;
   logic [6:0] lap_sec, lap_min;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lap_hold <= 1'b0;
         lap_sec  <= 7'd0;
         lap_min  <= 7'd0;
      end else if (c_press || state_nxt != RUN)
         lap_hold <= 1'b0;
      else if (press[2] && state == RUN) begin
         lap_hold <= ~lap_hold;
         if (!lap_hold) begin
            lap_sec <= sec_t;
            lap_min <= min_t;
         end
      end
   end

   assign disp_sec = lap_hold ? lap_sec : sec_t;
   assign disp_min = lap_hold ? lap_min : min_t;
`else
   assign disp_sec = sec_t;
   assign disp_min = min_t;
`endif

   assign {sec1, sec0} = disp_sec;
   assign {min1, min0} = disp_min;
   assign running      = (state == RUN);

   logic [3:0] digit;
   logic       blank;
   logic [7:0] seg_nxt;
   logic [3:0] an_nxt;

   always_comb begin
      digit = 4'd0;
      case (scan_idx)
         2'd0:    digit = disp_sec[3:0];
         2'd1:    digit = {1'b0, disp_sec[6:4]};
         2'd2:    digit = disp_min[3:0];
         default: digit = {1'b0, disp_min[6:4]};
      endcase
      // scan_idx[1]==0 selects the seconds pair, matching sw_sel=1
      blank   = (state == ADJUST) && blink && (scan_idx[1] == ~sel_s);
      seg_nxt = {scan_idx != 2'd2, blank ? 7'h7F : hex7(digit)};
      an_nxt  = ~(4'b0001 << scan_idx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'b1110;
         seg <= 8'hC0;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end
endmodule
